// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: Diff = A - B - Bin over W bits using one
// full-subtractor cell, a registered borrow and a start/done handshake.
module serial_subtractor #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Diff,
  output logic         Bout,
  output logic         Ovf
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [W-1:0]   sa_r;
  logic [W-1:0]   sb_r;
  logic [W-1:0]   acc_r;
  logic           br_r;
  logic           sign_a_r;
  logic           sign_b_r;
  logic [CW-1:0]  cnt_r;
  logic           bit_a_s;
  logic           bit_b_s;
  logic           d_s;
  logic           br_nxt_s;
  logic           last_s;
  logic [W-1:0]   acc_nxt_s;
  logic           busy_nxt_s;
  logic           done_nxt_s;

  // Full-subtractor cell on the current LSBs and the shifted-in result word.
  always_comb begin
    bit_a_s        = sa_r[0];
    bit_b_s        = sb_r[0];
    d_s            = bit_a_s ^ bit_b_s ^ br_r;
    br_nxt_s       = (~bit_a_s & bit_b_s) | (~(bit_a_s ^ bit_b_s) & br_r);
    acc_nxt_s      = acc_r >> 1;
    acc_nxt_s[W-1] = d_s;
    last_s         = (cnt_r == CW'(W - 1));
  end

  // State register with registered handshake outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= busy_nxt_s;
      done    <= done_nxt_s;
    end
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake values for the next cycle, decoded from the next state.
  always_comb begin
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = (state_nxt_s == ST_DONE);
  end

  // Operand shift registers, borrow flop, bit counter and result registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sa_r     <= '0;
      sb_r     <= '0;
      acc_r    <= '0;
      br_r     <= 1'b0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      cnt_r    <= '0;
      Diff     <= '0;
      Bout     <= 1'b0;
      Ovf      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            sa_r     <= A;
            sb_r     <= B;
            br_r     <= Bin;
            sign_a_r <= A[W-1];
            sign_b_r <= B[W-1];
            cnt_r    <= '0;
          end
        end
        ST_RUN: begin
          sa_r  <= sa_r >> 1;
          sb_r  <= sb_r >> 1;
          acc_r <= acc_nxt_s;
          br_r  <= br_nxt_s;
          if (last_s) begin
            // Overflow only possible when operand signs differ.
            Diff <= acc_nxt_s;
            Bout <= br_nxt_s;
            Ovf  <= (sign_a_r != sign_b_r) & (acc_nxt_s[W-1] != sign_a_r);
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (W=4): directed vectors, held start,
// operand toggling, mid-run reset and a full operand sweep.
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic [3:0] diff;
    logic       bout;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       RST;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Bin;
  logic       busy;
  logic       done;
  logic [3:0] Diff;
  logic       Bout;
  logic       Ovf;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   done_q[$];
  exp_t last;

  serial_subtractor #(.W(W)) dut (
    .CLK(clk), .RST(RST), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .Diff(Diff), .Bout(Bout), .Ovf(Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference: plain integer arithmetic, signed overflow by range check.
  function automatic exp_t model(logic [3:0] a, logic [3:0] b, logic bin);
    int   r, sa, sb, sr;
    exp_t e;
    r      = int'(a) - int'(b) - int'(bin);
    e.diff = 4'(r);
    e.bout = (r < 0);
    sa     = (a >= 4'd8) ? int'(a) - 16 : int'(a);
    sb     = (b >= 4'd8) ? int'(b) - 16 : int'(b);
    sr     = sa - sb - int'(bin);
    e.ovf  = (sr < -8) || (sr > 7);
    return e;
  endfunction

  task automatic chk(string nm, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!RST && done) begin
      exp_t e;
      n_done++;
      done_q.push_back(cyc);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got Diff=%0d Bout=%0b Ovf=%0b with no request pending",
                 Diff, Bout, Ovf);
      end else begin
        e = exp_q.pop_front();
        if ({Diff, Bout, Ovf} !== e) begin
          n_err++;
          $display("FAIL result: got Diff=%0d Bout=%0b Ovf=%0b expected Diff=%0d Bout=%0b Ovf=%0b",
                   Diff, Bout, Ovf, e.diff, e.bout, e.ovf);
        end
      end
    end
  end

  task automatic issue(logic [3:0] a, logic [3:0] b, logic bin, exp_t e);
    int prev, t, acc_c;
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    exp_q.push_back(e);
    prev = n_done;
    @(posedge clk);
    #1 acc_c = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("hold_result", int'({Diff, Bout, Ovf}), int'(last));
    chk("busy_run", int'(busy), 1);
    t = 0;
    while (n_done == prev && t < 20) begin
      @(posedge clk);
      t++;
    end
    chk("done_seen", n_done - prev, 1);
    if (n_done != prev) chk("latency", done_q[$] - acc_c, W);
    #1;
    chk("done_width", int'(done), 0);
    chk("idle_after", int'(busy), 0);
    last = e;
  endtask

  initial begin
    int prev, lows;
    bit seen;
    exp_t e;
    RST = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    last = '0;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'({Diff, Bout, Ovf}), 0);
    repeat (2) @(negedge clk);
    RST = 1'b0;

    // Hand-computed directed vectors.
    issue(4'd9,  4'd3,  1'b0, '{diff: 4'd6,  bout: 1'b0, ovf: 1'b1});
    issue(4'd3,  4'd5,  1'b1, '{diff: 4'd13, bout: 1'b1, ovf: 1'b0});
    issue(4'd0,  4'd0,  1'b1, '{diff: 4'd15, bout: 1'b1, ovf: 1'b0});
    issue(4'd15, 4'd15, 1'b0, '{diff: 4'd0,  bout: 1'b0, ovf: 1'b0});

    // Start held high for 20 cycles: accepts at edges 0, 6, 12, 18.
    done_q.delete();
    prev = n_done;
    lows = 0;
    e = '{diff: 4'd3, bout: 1'b0, ovf: 1'b0};
    @(negedge clk);
    A = 4'd6; B = 4'd2; Bin = 1'b1; start = 1'b1;
    repeat (4) exp_q.push_back(e);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!busy) lows++;
    end
    start = 1'b0;
    repeat (10) @(posedge clk);
    chk("held_done_count", n_done - prev, 4);
    chk("held_busy_low_cycles", lows, 3);
    for (int i = 1; i < done_q.size(); i++)
      chk("done_spacing", done_q[i] - done_q[i-1], W + 2);
    last = e;

    // Operands toggled during RUN; start pulse in DONE must be ignored.
    prev = n_done;
    e = '{diff: 4'd3, bout: 1'b0, ovf: 1'b1};
    @(negedge clk);
    A = 4'd10; B = 4'd7; Bin = 1'b0; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      A = A ^ 4'hF; B = B + 4'd1; Bin = ~Bin;
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", int'(busy), 0);
      end
    end
    chk("toggle_done_seen", n_done - prev, 1);
    repeat (8) @(posedge clk);
    chk("no_extra_done", n_done - prev, 1);
    last = e;

    // Reset in the middle of RUN aborts the request.
    prev = n_done;
    @(negedge clk);
    A = 4'd12; B = 4'd5; Bin = 1'b0; start = 1'b1;
    exp_q.push_back(model(4'd12, 4'd5, 1'b0));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    RST = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_diff", int'(Diff), 0);
    chk("midrst_bout", int'(Bout), 0);
    chk("midrst_ovf", int'(Ovf), 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    RST = 1'b0;
    repeat (8) @(posedge clk);
    chk("aborted_no_done", n_done - prev, 0);
    last = '0;
    issue(4'd5, 4'd12, 1'b1, model(4'd5, 4'd12, 1'b1));

    // Full sweep against the integer model.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          issue(4'(a), 4'(b), 1'(c), model(4'(a), 4'(b), 1'(c)));

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
